// File: rtl/led_pattern_gen_if.sv
// Config/observe bundle for led_pattern_gen: write-only channel config, phase sync,
// and the tick/led outputs.
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 8
);
    localparam int CW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                cfg_we;
    logic [CW-1:0]       cfg_chan;
    logic [1:0]          cfg_mode;
    logic [15:0]         cfg_arg;
    logic                sync;
    logic                tick;
    logic [NUM_LEDS-1:0] led;

    modport master (output cfg_we, cfg_chan, cfg_mode, cfg_arg, sync, input tick, led);
    modport slave  (input cfg_we, cfg_chan, cfg_mode, cfg_arg, sync, output tick, led);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter feeding one
// mode/blink engine per channel (OFF, ON, BLINK half-period, PWM duty).
module led_pattern_chan #(
    parameter int PWM_BITS     = 8,
    parameter int DEFAULT_HALF = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    input  logic                i_sync,
    input  logic                i_wr,
    input  logic [1:0]          i_mode,
    input  logic [15:0]         i_arg,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led
);
    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_PWM   = 2'b11;

    logic [1:0]  r_mode;
    logic [15:0] r_arg;
    logic [15:0] r_bcnt;
    logic        r_bstate;
    logic        r_led;
    logic [15:0] w_lim;
    logic        w_next;

    // Half-period of 0 behaves as 1, so the limit never underflows.
    assign w_lim = (r_arg == 16'd0) ? 16'd0 : r_arg - 16'd1;

    always_comb begin
        w_next = 1'b0;
        case (r_mode)
            M_OFF:   w_next = 1'b0;
            M_ON:    w_next = 1'b1;
            M_BLINK: w_next = r_bstate;
            M_PWM:   w_next = (i_pwm_cnt < r_arg[PWM_BITS-1:0]);
            default: w_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= M_BLINK;
            r_arg    <= 16'(DEFAULT_HALF);
            r_bcnt   <= 16'd0;
            r_bstate <= 1'b1;
            r_led    <= 1'b1;
        end else begin
            r_led <= w_next;
            // A write restarts the phase and swallows a coincident tick.
            if (i_wr) begin
                r_mode   <= i_mode;
                r_arg    <= i_arg;
                r_bcnt   <= 16'd0;
                r_bstate <= 1'b1;
            end else if (i_sync) begin
                r_bcnt   <= 16'd0;
                r_bstate <= 1'b1;
            end else if (i_tick) begin
                if (r_bcnt >= w_lim) begin
                    r_bcnt   <= 16'd0;
                    r_bstate <= ~r_bstate;
                end else begin
                    r_bcnt <= r_bcnt + 16'd1;
                end
            end
        end
    end

    assign o_led = r_led;
endmodule

module led_pattern_gen #(
    parameter int NUM_LEDS     = 8,
    parameter int CLK_FREQ_HZ  = 200000000,
    parameter int TICK_HZ      = 1000,
    parameter int PWM_BITS     = 8,
    parameter int DEFAULT_HALF = 500
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_gen_if.slave   bus
);
    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam int CW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [PRE_W-1:0]    r_presc;
    logic                r_tick;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LEDS-1:0] w_wr;
    logic [NUM_LEDS-1:0] w_led;
    logic                w_wrap;

    assign w_wrap = (r_presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_pwm_cnt <= '0;
        end else if (bus.sync) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc   <= w_wrap ? '0 : r_presc + 1'b1;
            r_tick    <= w_wrap;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Out-of-range channel indices match no decode line and are dropped.
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        assign w_wr[g] = bus.cfg_we && (bus.cfg_chan == CW'(g));

        led_pattern_chan #(
            .PWM_BITS     (PWM_BITS),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (r_tick),
            .i_sync    (bus.sync),
            .i_wr      (w_wr[g]),
            .i_mode    (bus.cfg_mode),
            .i_arg     (bus.cfg_arg),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[g])
        );
    end

    assign bus.led  = w_led;
    assign bus.tick = r_tick;
endmodule
